alarme_sirene: RTL and testbench
================================

# alarme_sirene

Sequential siren controller downstream of the bank-vault alarm logic in `top`. It consumes the combinational alarm condition (`porta & (~relog | inter)`) as `disparo` and applies a grace period during which the alarm can be cancelled. It then drives a blinking siren for a bounded time and afterwards holds a latched "alarm occurred" indicator until the alarm is disarmed. Outputs feed `LED` (siren and latch) and `SEG`/LCD (state and counter).

## Interface

Parameters:
- `ATRASO`, default 3: grace period, in cycles, between trigger and siren. Range 1..2^NBITS_CNT.
- `DURACAO`, default 10: siren duration in cycles. Range 1..2^NBITS_CNT.
- `NBITS_CNT`, default 4: counter width.

Ports:
- `clk_2`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `disparo`  in  1: alarm condition, level-sensitive.
- `desarme`  in  1: disarm switch; only its rising edge is an event.
- `sirene`  out  1: siren drive, registered.
- `travado`  out  1: latched alarm indicator, registered.
- `estado`  out  2: current state code, registered.
- `contagem`  out  NBITS_CNT: current counter value, registered.

## Operation

- Disarm event detection:
  - `desarme_q` is a register holding `desarme` from the previous cycle; reset value 0.
  - Disarm event `ev = desarme & ~desarme_q`. It is combinational on the current input, so there is no added latency.
- State encoding: ARMADO=0, ESPERA=1, TOCANDO=2, SILENCIO=3.
- Transition priority at every edge: `reset` > `ev` > `disparo` > counter terminal count.
- ARMADO:
  - `ev` → stay in ARMADO.
  - Else `disparo` → ESPERA with `cnt`←0.
  - Else hold.
- ESPERA:
  - `ev` → ARMADO with `cnt`←0.
  - Else if `cnt == ATRASO-1` → TOCANDO with `cnt`←0, `sirene`←1, `travado`←1.
  - Else `cnt`←`cnt`+1.
- TOCANDO:
  - `ev` → ARMADO with `cnt`←0, `sirene`←0, `travado`←0.
  - Else if `cnt == DURACAO-1` → SILENCIO with `cnt`←0, `sirene`←0.
  - Else `cnt`←`cnt`+1 and `sirene`←~`sirene`.
- SILENCIO:
  - `ev` → ARMADO with `travado`←0.
  - Else hold, with `sirene`=0 and `travado`=1, indefinitely.
- `disparo` is ignored in ESPERA, TOCANDO and SILENCIO.
- If `disparo` is still high on return to ARMADO, the block re-enters ESPERA on the next edge.
- Counter arithmetic:
  - Unsigned, NBITS_CNT wide.
  - The counter never exceeds `max(ATRASO,DURACAO)-1`, so it never wraps.
  - Comparisons are against `ATRASO-1` and `DURACAO-1` truncated to NBITS_CNT.
- Outputs: `contagem`=`cnt` and `estado`=state register. No combinational path from inputs to outputs.

## Timing

- Reset values (when `reset` is sampled high): `estado`=0, `contagem`=0, `sirene`=0, `travado`=0, `desarme_q`=0.
- Reset mid-operation aborts any state on the next edge and overrides a simultaneous `disparo` or `ev`.
- Trigger latency: `disparo` sampled high at edge t in ARMADO gives `estado`=1 after edge t.
- ESPERA lasts exactly ATRASO cycles (`contagem` 0..ATRASO-1). With ATRASO=1, TOCANDO is entered at edge t+1.
- TOCANDO lasts exactly DURACAO cycles.
  - `sirene` pattern is 1,0,1,0,…, starting with 1.
  - SILENCIO is entered at edge t+ATRASO+DURACAO.
- Disarm latency: an `ev` at edge e gives ARMADO after edge e, from any state.
- Holding `desarme` high produces one event only. Later triggers proceed normally while it stays high.
- `ev` and `disparo` at the same edge in ARMADO: stay in ARMADO.
- `ev` at a terminal count: `ev` wins, next state is ARMADO.

## Test plan

All scenarios use ATRASO=3, DURACAO=4.

- **Reset:** `reset`=1 for 2 cycles with `disparo`=1 → `estado`=0, `sirene`=0, `travado`=0, `contagem`=0. After `reset` falls, with `disparo` still 1 → `estado`=1 one edge later.
- **Full alarm sequence:** 1-cycle `disparo` pulse at edge t.
  - `estado`=1 with `contagem` 0,1,2 after edges t..t+2.
  - After edge t+3: `estado`=2, `sirene`=1, `travado`=1.
  - `sirene` is 1,0,1,0 after edges t+3..t+6.
  - After edge t+7: `estado`=3, `sirene`=0, `travado`=1, held for 20 cycles.
  - `desarme` rise → `estado`=0, `travado`=0.
- **Cancel in grace period:** `desarme` rises during ESPERA at `contagem`=1 → `estado`=0 at the next edge; `sirene` and `travado` never go to 1.
- **Held disarm:** `desarme` rises in ARMADO (no effect) and stays high; then a `disparo` pulse → full sequence as in the full-alarm scenario, with no cancellation.
- **Simultaneous events:** `disparo`=1 and `desarme` rise at the same edge in ARMADO → `estado` stays 0. Next edge (`disparo` still 1, `desarme` held) → `estado`=1.
- **Abort:** `reset` asserted while `estado`=2 and `sirene`=1 → all outputs 0 after that edge.

Source files
------------

// File: rtl/alarme_sirene.sv
// alarme_sirene: siren controller fed by the vault alarm condition.
// A trigger opens a cancellable grace period. After it, the siren blinks for a
// bounded time. The "alarm occurred" latch then stays set until disarmed.
//
// Ports:
//   clk_2    in  1          clock, rising edge
//   reset    in  1          synchronous, active-high
//   disparo  in  1          alarm condition (level)
//   desarme  in  1          disarm switch (rising edge is the event)
//   sirene   out 1          siren drive (registered)
//   travado  out 1          latched alarm indicator (registered)
//   estado   out 2          state code (registered)
//   contagem out NBITS_CNT  counter value (registered)
module alarme_sirene #(
  parameter int unsigned ATRASO    = 3,
  parameter int unsigned DURACAO   = 10,
  parameter int unsigned NBITS_CNT = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 disparo,
  input  logic                 desarme,
  output logic                 sirene,
  output logic                 travado,
  output logic [1:0]           estado,
  output logic [NBITS_CNT-1:0] contagem
);

  typedef enum logic [1:0] {
    ARMADO   = 2'd0,
    ESPERA   = 2'd1,
    TOCANDO  = 2'd2,
    SILENCIO = 2'd3
  } estado_t;

  // Terminal counts, truncated to the counter width
  localparam logic [NBITS_CNT-1:0] ATRASO_TC  = NBITS_CNT'(ATRASO - 1);
  localparam logic [NBITS_CNT-1:0] DURACAO_TC = NBITS_CNT'(DURACAO - 1);

  estado_t               state_q, state_d;
  logic [NBITS_CNT-1:0]  cnt_q, cnt_d;
  logic                  sirene_q, sirene_d;
  logic                  travado_q, travado_d;
  logic                  desarme_q, desarme_d;
  logic                  ev_c;

  // Disarm event: rising edge of desarme, combinational on the current input
  assign ev_c = desarme & ~desarme_q;

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sirene_d  = sirene_q;
    travado_d = travado_q;
    desarme_d = desarme;

    case (state_q)
      ARMADO: begin
        if (!ev_c && disparo) begin
          state_d = ESPERA;
          cnt_d   = '0;
        end
      end
      ESPERA: begin
        if (ev_c) begin
          state_d = ARMADO;
          cnt_d   = '0;
        end else if (cnt_q == ATRASO_TC) begin
          state_d   = TOCANDO;
          cnt_d     = '0;
          sirene_d  = 1'b1;
          travado_d = 1'b1;
        end else begin
          cnt_d = cnt_q + NBITS_CNT'(1);
        end
      end
      TOCANDO: begin
        if (ev_c) begin
          state_d   = ARMADO;
          cnt_d     = '0;
          sirene_d  = 1'b0;
          travado_d = 1'b0;
        end else if (cnt_q == DURACAO_TC) begin
          state_d  = SILENCIO;
          cnt_d    = '0;
          sirene_d = 1'b0;
        end else begin
          cnt_d    = cnt_q + NBITS_CNT'(1);
          sirene_d = ~sirene_q;
        end
      end
      SILENCIO: begin
        if (ev_c) begin
          state_d   = ARMADO;
          travado_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARMADO;
        cnt_d     = '0;
        sirene_d  = 1'b0;
        travado_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q   <= ARMADO;
      cnt_q     <= '0;
      sirene_q  <= 1'b0;
      travado_q <= 1'b0;
      desarme_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sirene_q  <= sirene_d;
      travado_q <= travado_d;
      desarme_q <= desarme_d;
    end
  end

  assign sirene   = sirene_q;
  assign travado  = travado_q;
  assign estado   = state_q;
  assign contagem = cnt_q;

endmodule

// File: tb/tb_alarme_sirene.sv
// Bench for alarme_sirene (ATRASO=3, DURACAO=4). The reference model tracks
// only "idle or triggered at edge t0" and derives outputs from elapsed time.
module tb_alarme_sirene;

  localparam int unsigned A  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned NB = 4;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          disparo = 1'b1;
  logic          desarme = 1'b0;
  logic          sirene;
  logic          travado;
  logic [1:0]    estado;
  logic [NB-1:0] contagem;

  int n_chk  = 0;
  int n_pass = 0;

  alarme_sirene #(.ATRASO(A), .DURACAO(D), .NBITS_CNT(NB)) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .disparo  (disparo),
    .desarme  (desarme),
    .sirene   (sirene),
    .travado  (travado),
    .estado   (estado),
    .contagem (contagem)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: idle, or triggered at edge m_t0
  int m_edge  = 0;
  int m_t0    = 0;
  bit m_idle  = 1'b1;
  bit m_dq    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk_2) begin
    bit ev;
    if (reset) begin
      m_idle  = 1'b1;
      m_dq    = 1'b0;
      m_valid = 1'b1;
    end else begin
      ev   = desarme && !m_dq;
      m_dq = desarme;
      if (ev) m_idle = 1'b1;
      else if (m_idle && disparo) begin
        m_idle = 1'b0;
        m_t0   = m_edge;
      end
    end
    m_edge++;
  end

  // Expected {estado, contagem, sirene, travado} after the latest edge
  function automatic logic [7:0] model_out();
    int k;
    if (m_idle) return 8'h00;
    k = (m_edge - 1) - m_t0;
    if (k < int'(A)) return {2'd1, 4'(k), 1'b0, 1'b0};
    if (k < int'(A + D)) return {2'd2, 4'(k - int'(A)), ((k - int'(A)) % 2) == 0, 1'b1};
    return {2'd3, 4'd0, 1'b0, 1'b1};
  endfunction

  function automatic logic [7:0] dut_out();
    return {estado, contagem, sirene, travado};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk_2) begin
    if (m_valid) begin
      n_chk++;
      if (dut_out() === model_out()) n_pass++;
      else $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, dut_out(), model_out());
    end
  end

  task automatic tick();
    @(posedge clk_2);
    #2;
  endtask

  // Hand-computed expectation, checked against both DUT and model
  task automatic lit(input string nm, input logic [1:0] e, input logic [3:0] c,
                     input logic s, input logic t);
    logic [7:0] want;
    want = {e, c, s, t};
    n_chk++;
    if (dut_out() === want) n_pass++;
    else $display("FAIL %s dut actual=%h required=%h", nm, dut_out(), want);
    n_chk++;
    if (model_out() === want) n_pass++;
    else $display("FAIL %s model actual=%h required=%h", nm, model_out(), want);
  endtask

  initial begin
    // Reset with disparo high
    tick(); tick();
    lit("reset", 2'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    lit("post_reset_trigger", 2'd1, 4'd0, 1'b0, 1'b0);
    disparo = 1'b0;
    repeat (4) tick();
    desarme = 1'b1; tick();
    lit("disarm_from_tocando", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0; tick();

    // Full alarm sequence
    disparo = 1'b1; tick();
    lit("full_t0", 2'd1, 4'd0, 1'b0, 1'b0);
    disparo = 1'b0; tick();
    lit("full_t1", 2'd1, 4'd1, 1'b0, 1'b0);
    tick(); lit("full_t2", 2'd1, 4'd2, 1'b0, 1'b0);
    tick(); lit("full_t3", 2'd2, 4'd0, 1'b1, 1'b1);
    tick(); lit("full_t4", 2'd2, 4'd1, 1'b0, 1'b1);
    tick(); lit("full_t5", 2'd2, 4'd2, 1'b1, 1'b1);
    tick(); lit("full_t6", 2'd2, 4'd3, 1'b0, 1'b1);
    tick(); lit("full_t7", 2'd3, 4'd0, 1'b0, 1'b1);
    repeat (20) tick();
    lit("silencio_hold", 2'd3, 4'd0, 1'b0, 1'b1);
    desarme = 1'b1; tick();
    lit("disarm_silencio", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0; tick();

    // Cancel during grace period
    disparo = 1'b1; tick();
    disparo = 1'b0; tick();
    lit("cancel_cnt1", 2'd1, 4'd1, 1'b0, 1'b0);
    desarme = 1'b1; tick();
    lit("cancel", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0;
    repeat (5) tick();
    lit("cancel_idle", 2'd0, 4'd0, 1'b0, 1'b0);

    // Held disarm: one event only, later trigger runs to completion
    desarme = 1'b1; tick();
    lit("held_ev_armado", 2'd0, 4'd0, 1'b0, 1'b0);
    disparo = 1'b1; tick();
    lit("held_trigger", 2'd1, 4'd0, 1'b0, 1'b0);
    disparo = 1'b0;
    repeat (3) tick();
    lit("held_tocando", 2'd2, 4'd0, 1'b1, 1'b1);
    repeat (4) tick();
    lit("held_silencio", 2'd3, 4'd0, 1'b0, 1'b1);
    desarme = 1'b0; tick();
    lit("fall_no_event", 2'd3, 4'd0, 1'b0, 1'b1);

    // Simultaneous disarm rise and trigger in ARMADO
    desarme = 1'b1; tick();
    lit("rearm", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0; tick();
    desarme = 1'b1; disparo = 1'b1; tick();
    lit("simul_stay", 2'd0, 4'd0, 1'b0, 1'b0);
    tick();
    lit("simul_next", 2'd1, 4'd0, 1'b0, 1'b0);
    disparo = 1'b0;

    // Abort with reset while siren is on
    repeat (3) tick();
    lit("abort_pre", 2'd2, 4'd0, 1'b1, 1'b1);
    reset = 1'b1; tick();
    lit("abort", 2'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0; tick();
    lit("post_abort_ev", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0; tick();

    // Disarm at the grace-period terminal count wins
    disparo = 1'b1; tick();
    disparo = 1'b0; tick(); tick();
    lit("tc_pre", 2'd1, 4'd2, 1'b0, 1'b0);
    desarme = 1'b1; tick();
    lit("ev_at_tc", 2'd0, 4'd0, 1'b0, 1'b0);
    desarme = 1'b0;
    repeat (3) tick();

    @(posedge clk_2); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
